// File: rtl/mem_arbiter_if.sv
// Signal bundle between the CPU fetch/data stages, the unified-memory arbiter and the memory.
// The slave view belongs to the arbiter; the master view belongs to the CPU stages plus the memory.
interface mem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              if_stall;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_valid;
  logic              dm_stall;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_rdata, if_valid, if_stall,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_rdata, dm_valid, dm_stall,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_rdata, if_valid, if_stall,
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_rdata, dm_valid, dm_stall,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch and data access.
// Data wins collisions; a streak counter forces a fetch grant after STARVE_MAX data grants in a row.
module mem_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic         clk,
  input  logic         SYS_reset_n,
  mem_arbiter_if.slave bus
);
  localparam logic [3:0] LAT_LOAD   = 4'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                 state_reg, state_next;
  logic                   owner_reg, owner_next;
  logic [3:0]             streak_reg, streak_next;
  logic [3:0]             cnt_reg, cnt_next;
  logic                   mem_we_reg, mem_we_next;
  logic [ADDR_W-1:0]      mem_addr_reg, mem_addr_next;
  logic [DATA_W-1:0]      mem_wdata_reg, mem_wdata_next;
  logic [1:0][DATA_W-1:0] rdata_reg, rdata_next;
  logic                   grant_if, grant_dm;
  logic [1:0]             req_vec, valid_vec, stall_vec;

  always_ff @(posedge clk or negedge SYS_reset_n) begin
    if (!SYS_reset_n) begin
      state_reg     <= IDLE;
      owner_reg     <= 1'b0;
      streak_reg    <= '0;
      cnt_reg       <= '0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      rdata_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      owner_reg     <= owner_next;
      streak_reg    <= streak_next;
      cnt_reg       <= cnt_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      rdata_reg     <= rdata_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    owner_next     = owner_reg;
    streak_next    = streak_reg;
    cnt_next       = cnt_reg;
    mem_we_next    = mem_we_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    rdata_next     = rdata_reg;
    grant_dm       = 1'b0;
    grant_if       = 1'b0;
    case (state_reg)
      IDLE: begin
        grant_dm = bus.dm_req && !(bus.if_req && streak_reg == STARVE_LIM);
        grant_if = bus.if_req && !grant_dm;
        if (grant_dm) begin
          owner_next     = 1'b1;
          mem_addr_next  = bus.dm_addr;
          mem_we_next    = bus.dm_we;
          mem_wdata_next = bus.dm_wdata;
        end else if (grant_if) begin
          owner_next     = 1'b0;
          mem_addr_next  = bus.if_addr;
          mem_we_next    = 1'b0;
          mem_wdata_next = '0;
        end
        // Only data grants that keep a waiting fetch waiting extend the streak.
        if (grant_dm && bus.if_req)
          streak_next = (streak_reg == 4'hF) ? streak_reg : streak_reg + 4'd1;
        else
          streak_next = '0;
        if (grant_dm || grant_if) begin
          state_next = BUSY;
          cnt_next   = LAT_LOAD;
        end
      end
      BUSY: begin
        if (cnt_reg == '0) begin
          state_next  = RESP;
          mem_we_next = 1'b0;
          if (!mem_we_reg)
            rdata_next[owner_reg] = bus.mem_rdata;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Index 0 is the fetch port, index 1 the data port, matching the owner encoding.
  assign req_vec = {bus.dm_req, bus.if_req};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      assign valid_vec[gi] = (state_reg == RESP) && (owner_reg == 1'(gi));
      assign stall_vec[gi] = req_vec[gi] & ~valid_vec[gi];
    end
  endgenerate

  assign bus.if_rdata  = rdata_reg[0];
  assign bus.dm_rdata  = rdata_reg[1];
  assign bus.if_valid  = valid_vec[0];
  assign bus.dm_valid  = valid_vec[1];
  assign bus.if_stall  = stall_vec[0];
  assign bus.dm_stall  = stall_vec[1];
  assign bus.mem_en    = (state_reg == BUSY);
  assign bus.mem_we    = mem_we_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_wdata = mem_wdata_reg;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized run
// checked cycle by cycle against a grant/latency reference model.
module tb_mem_arbiter;
  localparam int AW   = 8;
  localparam int DW   = 32;
  localparam int LAT  = 2;
  localparam int SMAX = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc_cnt = 0;
  logic        rd_ovr_en = 1'b0;
  logic [31:0] rd_ovr_val = '0;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) a_if ();
  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b_if ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .SYS_reset_n(rst_n), .bus(a_if)
  );
  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1), .STARVE_MAX(SMAX)) dut1 (
    .clk(clk), .SYS_reset_n(rst_n), .bus(b_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Memory contents change every cycle so that the capture cycle matters.
  function automatic logic [31:0] mem_word(input logic [7:0] a, input int unsigned c);
    logic [31:0] cv;
    cv = c;
    return {a, cv[7:0], ~a, cv[15:8]} ^ 32'h3C5A_9617;
  endfunction

  assign a_if.mem_rdata = rd_ovr_en ? rd_ovr_val : mem_word(a_if.mem_addr, cyc_cnt);
  assign b_if.mem_rdata = mem_word(b_if.mem_addr, cyc_cnt);

  task automatic test_reset();
    rst_n = 1'b0;
    a_if.if_req = 1'b1;
    a_if.if_addr = 8'h0C;
    repeat (2) @(negedge clk);
    checks++;
    if ({a_if.mem_en, a_if.mem_we, a_if.if_valid, a_if.dm_valid} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got en/we/ifv/dmv=%b want 0000",
               {a_if.mem_en, a_if.mem_we, a_if.if_valid, a_if.dm_valid});
    end
    checks++;
    if ({a_if.if_rdata, a_if.dm_rdata, a_if.mem_wdata, a_if.mem_addr} !== '0) begin
      errors++;
      $display("FAIL reset_data: got if_rdata=%h dm_rdata=%h mem_wdata=%h mem_addr=%h want all 0",
               a_if.if_rdata, a_if.dm_rdata, a_if.mem_wdata, a_if.mem_addr);
    end
    checks++;
    if ({a_if.if_stall, a_if.dm_stall} !== 2'b10) begin
      errors++;
      $display("FAIL reset_stall: got if/dm stall=%b want 10", {a_if.if_stall, a_if.dm_stall});
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (a_if.mem_en !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_busy: got mem_en=%b want 1", a_if.mem_en);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({a_if.mem_en, a_if.if_valid, a_if.if_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_async: got mem_en=%b if_valid=%b if_rdata=%h want 0",
               a_if.mem_en, a_if.if_valid, a_if.if_rdata);
    end
    a_if.if_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if ({a_if.mem_en, a_if.if_valid, a_if.dm_valid, a_if.if_rdata, a_if.dm_rdata} !== '0) begin
        errors++;
        $display("FAIL reset_after: cycle %0d got en=%b ifv=%b dmv=%b if_rdata=%h dm_rdata=%h want 0",
                 k, a_if.mem_en, a_if.if_valid, a_if.dm_valid, a_if.if_rdata, a_if.dm_rdata);
      end
    end
  endtask

  task automatic test_single_fetch();
    @(posedge clk); #1;
    rd_ovr_en = 1'b1;
    rd_ovr_val = 32'h2008_000A;
    a_if.if_req = 1'b1;
    a_if.if_addr = 8'h04;
    for (int k = 0; k <= LAT + 1; k++) begin
      @(negedge clk);
      checks++;
      if ({a_if.mem_en, a_if.if_valid, a_if.if_stall} !== {k >= 1 && k <= LAT, k == LAT + 1, k <= LAT}) begin
        errors++;
        $display("FAIL fetch_ctrl: cycle %0d got en/valid/stall=%b%b%b want %b%b%b", k,
                 a_if.mem_en, a_if.if_valid, a_if.if_stall, k >= 1 && k <= LAT, k == LAT + 1, k <= LAT);
      end
      if (k >= 1 && k <= LAT) begin
        checks++;
        if (a_if.mem_addr !== 8'h04 || a_if.mem_we !== 1'b0) begin
          errors++;
          $display("FAIL fetch_addr: cycle %0d got mem_addr=%h mem_we=%b want 04 0", k, a_if.mem_addr, a_if.mem_we);
        end
      end
      if (k == LAT + 1) begin
        checks++;
        if (a_if.if_rdata !== 32'h2008_000A) begin
          errors++;
          $display("FAIL fetch_rdata: got %h want 2008000a", a_if.if_rdata);
        end
        $display("txn fetch addr=04 rdata=%h", a_if.if_rdata);
      end
      if (k <= LAT) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    a_if.if_req = 1'b0;
    rd_ovr_en = 1'b0;
  endtask

  task automatic test_dm_write();
    logic [7:0]  ad;
    logic [31:0] wd, exp_rd, prior_rd;
    logic        w;
    prior_rd = '0;
    exp_rd = '0;
    for (int t = 0; t < 2; t++) begin
      w  = (t == 1);
      ad = w ? 8'h10 : 8'h20;
      wd = w ? 32'hDEAD_BEEF : 32'h0;
      @(posedge clk); #1;
      a_if.dm_req = 1'b1;
      a_if.dm_we = w;
      a_if.dm_addr = ad;
      a_if.dm_wdata = wd;
      for (int k = 0; k <= LAT + 1; k++) begin
        @(negedge clk);
        if (k == LAT) exp_rd = w ? prior_rd : mem_word(ad, cyc_cnt);
        checks++;
        if ({a_if.mem_en, a_if.dm_valid, a_if.dm_stall} !== {k >= 1 && k <= LAT, k == LAT + 1, k <= LAT}) begin
          errors++;
          $display("FAIL dm_ctrl: access %0d cycle %0d got en/valid/stall=%b%b%b", t, k,
                   a_if.mem_en, a_if.dm_valid, a_if.dm_stall);
        end
        if (k >= 1 && k <= LAT) begin
          checks++;
          if (a_if.mem_addr !== ad || a_if.mem_we !== w || (w && a_if.mem_wdata !== wd)) begin
            errors++;
            $display("FAIL dm_bus: access %0d cycle %0d got addr=%h we=%b wdata=%h want %h %b %h",
                     t, k, a_if.mem_addr, a_if.mem_we, a_if.mem_wdata, ad, w, wd);
          end
        end
        if (k == LAT + 1) begin
          checks++;
          if (a_if.dm_rdata !== exp_rd || a_if.mem_we !== 1'b0) begin
            errors++;
            $display("FAIL dm_rdata: access %0d got rdata=%h mem_we=%b want %h 0", t, a_if.dm_rdata, a_if.mem_we, exp_rd);
          end
          $display("txn data %s addr=%h wdata=%h rdata=%h", w ? "write" : "read", ad, wd, a_if.dm_rdata);
          prior_rd = exp_rd;
        end
        if (k <= LAT) begin @(posedge clk); #1; end
      end
      @(posedge clk); #1;
      a_if.dm_req = 1'b0;
      a_if.dm_we = 1'b0;
    end
  endtask

  task automatic test_collision();
    logic [31:0] dm_exp, if_exp;
    logic        en_exp;
    dm_exp = '0;
    if_exp = '0;
    @(posedge clk); #1;
    a_if.if_req = 1'b1;
    a_if.if_addr = 8'h08;
    a_if.dm_req = 1'b1;
    a_if.dm_we = 1'b0;
    a_if.dm_addr = 8'h30;
    a_if.dm_wdata = '0;
    for (int k = 0; k <= 2 * LAT + 3; k++) begin
      @(negedge clk);
      en_exp = (k >= 1 && k <= LAT) || (k >= LAT + 3 && k <= 2 * LAT + 2);
      if (k == LAT) dm_exp = mem_word(8'h30, cyc_cnt);
      if (k == 2 * LAT + 2) if_exp = mem_word(8'h08, cyc_cnt);
      checks++;
      if ({a_if.mem_en, a_if.dm_valid, a_if.if_valid, a_if.if_stall} !==
          {en_exp, k == LAT + 1, k == 2 * LAT + 3, k < 2 * LAT + 3}) begin
        errors++;
        $display("FAIL coll_ctrl: cycle %0d got en/dmv/ifv/ifstall=%b%b%b%b want %b%b%b%b", k,
                 a_if.mem_en, a_if.dm_valid, a_if.if_valid, a_if.if_stall,
                 en_exp, k == LAT + 1, k == 2 * LAT + 3, k < 2 * LAT + 3);
      end
      if (en_exp) begin
        checks++;
        if (a_if.mem_addr !== ((k <= LAT) ? 8'h30 : 8'h08)) begin
          errors++;
          $display("FAIL coll_addr: cycle %0d got %h want %h", k, a_if.mem_addr, (k <= LAT) ? 8'h30 : 8'h08);
        end
      end
      if (k == LAT + 1) begin
        checks++;
        if (a_if.dm_rdata !== dm_exp) begin
          errors++;
          $display("FAIL coll_dm_rdata: got %h want %h", a_if.dm_rdata, dm_exp);
        end
        $display("txn collision data read addr=30 rdata=%h", a_if.dm_rdata);
      end
      if (k == 2 * LAT + 3) begin
        checks++;
        if (a_if.if_rdata !== if_exp) begin
          errors++;
          $display("FAIL coll_if_rdata: got %h want %h", a_if.if_rdata, if_exp);
        end
        $display("txn collision fetch addr=08 rdata=%h", a_if.if_rdata);
      end
      if (k < 2 * LAT + 3) begin
        @(posedge clk); #1;
        if (k == LAT + 1) a_if.dm_req = 1'b0;
      end
    end
    @(posedge clk); #1;
    a_if.if_req = 1'b0;
  endtask

  task automatic test_starvation();
    int n, cyc;
    bit exp_dm;
    n = 0;
    cyc = 0;
    @(posedge clk); #1;
    a_if.if_req = 1'b1;
    a_if.if_addr = 8'h50;
    a_if.dm_req = 1'b1;
    a_if.dm_we = 1'b0;
    a_if.dm_addr = 8'h60;
    while (n < 8 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (a_if.if_valid === 1'b1 || a_if.dm_valid === 1'b1) begin
        exp_dm = (n % (SMAX + 1)) != SMAX;
        checks++;
        if ({a_if.dm_valid, a_if.if_valid} !== {exp_dm, !exp_dm}) begin
          errors++;
          $display("FAIL starve_order: grant %0d got dm/if valid=%b%b want %b%b",
                   n, a_if.dm_valid, a_if.if_valid, exp_dm, !exp_dm);
        end
        $display("txn starve grant %0d to %s", n, a_if.dm_valid ? "data" : "fetch");
        n++;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL starve_timeout: got %0d grants want 8", n);
    end
    a_if.if_req = 1'b0;
    a_if.dm_req = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0]  cur;
    logic [31:0] exp;
    int          ph, nval;
    cur = 8'h40;
    exp = '0;
    nval = 0;
    @(posedge clk); #1;
    b_if.if_req = 1'b1;
    b_if.if_addr = cur;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      ph = k % 3;
      checks++;
      if ({b_if.mem_en, b_if.if_valid} !== {ph == 1, ph == 2}) begin
        errors++;
        $display("FAIL b2b_ctrl: cycle %0d got en/valid=%b%b want %b%b", k,
                 b_if.mem_en, b_if.if_valid, ph == 1, ph == 2);
      end
      if (ph == 1) begin
        checks++;
        if (b_if.mem_addr !== cur) begin
          errors++;
          $display("FAIL b2b_addr: cycle %0d got %h want %h", k, b_if.mem_addr, cur);
        end
        exp = mem_word(cur, cyc_cnt);
      end
      if (ph == 2) begin
        checks++;
        if (b_if.if_rdata !== exp) begin
          errors++;
          $display("FAIL b2b_rdata: cycle %0d got %h want %h", k, b_if.if_rdata, exp);
        end
        $display("txn b2b fetch %0d addr=%h rdata=%h", nval, cur, b_if.if_rdata);
        nval++;
      end
      @(posedge clk); #1;
      if (ph == 2) begin
        cur = cur + 8'd4;
        b_if.if_addr = cur;
      end
    end
    b_if.if_req = 1'b0;
  endtask

  task automatic test_random();
    bit          act, own, if_pend, dm_pend, exp_en, exp_ifv, exp_dmv;
    int          k, streak, ntx;
    logic        we_m, dm_we_l;
    logic [7:0]  ad_m, if_ad, dm_ad;
    logic [31:0] wd_m, dm_wd, rd_if_m, rd_dm_m;
    act = 0; own = 0; if_pend = 0; dm_pend = 0; k = 0; streak = 0; ntx = 0;
    we_m = 0; ad_m = '0; wd_m = '0; rd_if_m = '0; rd_dm_m = '0;
    if_ad = '0; dm_ad = '0; dm_wd = '0; dm_we_l = 0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    a_if.if_req = 1'b0;
    a_if.dm_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      if (!if_pend) begin
        if ($urandom_range(0, 3) != 0) begin
          if_pend = 1;
          if_ad = 8'($urandom);
        end
        a_if.if_req = if_pend;
        a_if.if_addr = if_ad;
      end
      if (!dm_pend) begin
        if ($urandom_range(0, 3) != 0) begin
          dm_pend = 1;
          dm_we_l = 1'($urandom);
          dm_ad = 8'($urandom);
          dm_wd = $urandom;
        end
        a_if.dm_req = dm_pend;
        a_if.dm_we = dm_we_l;
        a_if.dm_addr = dm_ad;
        a_if.dm_wdata = dm_wd;
      end
      @(negedge clk);
      exp_en = 0; exp_ifv = 0; exp_dmv = 0;
      if (act) begin
        k++;
        if (k <= LAT) begin
          exp_en = 1;
          if (k == LAT && !we_m) begin
            if (own) rd_dm_m = mem_word(ad_m, cyc_cnt);
            else     rd_if_m = mem_word(ad_m, cyc_cnt);
          end
        end else begin
          if (own) exp_dmv = 1; else exp_ifv = 1;
          act = 0;
        end
      end else if (dm_pend && !(if_pend && streak == SMAX)) begin
        act = 1; k = 0; own = 1; we_m = dm_we_l; ad_m = dm_ad; wd_m = dm_wd;
        streak = if_pend ? ((streak < 15) ? streak + 1 : 15) : 0;
      end else if (if_pend) begin
        act = 1; k = 0; own = 0; we_m = 0; ad_m = if_ad; streak = 0;
      end else begin
        streak = 0;
      end
      checks++;
      if ({a_if.mem_en, a_if.if_valid, a_if.dm_valid, a_if.if_stall, a_if.dm_stall} !==
          {exp_en, exp_ifv, exp_dmv, if_pend & ~exp_ifv, dm_pend & ~exp_dmv}) begin
        errors++;
        $display("FAIL rnd_ctrl: cycle %0d got en/ifv/dmv/ifs/dms=%b%b%b%b%b want %b%b%b%b%b", c,
                 a_if.mem_en, a_if.if_valid, a_if.dm_valid, a_if.if_stall, a_if.dm_stall,
                 exp_en, exp_ifv, exp_dmv, if_pend & ~exp_ifv, dm_pend & ~exp_dmv);
      end
      checks++;
      if (exp_en ? (a_if.mem_addr !== ad_m || a_if.mem_we !== we_m || (we_m && a_if.mem_wdata !== wd_m))
                 : (a_if.mem_we !== 1'b0)) begin
        errors++;
        $display("FAIL rnd_bus: cycle %0d got addr=%h we=%b wdata=%h want en=%b addr=%h we=%b wdata=%h", c,
                 a_if.mem_addr, a_if.mem_we, a_if.mem_wdata, exp_en, ad_m, we_m & exp_en, wd_m);
      end
      if (exp_ifv) begin
        checks++;
        if (a_if.if_rdata !== rd_if_m) begin
          errors++;
          $display("FAIL rnd_if_rdata: cycle %0d got %h want %h", c, a_if.if_rdata, rd_if_m);
        end
        $display("txn rnd %0d fetch addr=%h rdata=%h", ntx, ad_m, a_if.if_rdata);
        ntx++;
        if_pend = 0;
      end
      if (exp_dmv) begin
        checks++;
        if (a_if.dm_rdata !== rd_dm_m) begin
          errors++;
          $display("FAIL rnd_dm_rdata: cycle %0d got %h want %h", c, a_if.dm_rdata, rd_dm_m);
        end
        $display("txn rnd %0d data %s addr=%h wdata=%h rdata=%h", ntx, we_m ? "write" : "read",
                 ad_m, wd_m, a_if.dm_rdata);
        ntx++;
        dm_pend = 0;
      end
    end
    @(posedge clk); #1;
    a_if.if_req = 1'b0;
    a_if.dm_req = 1'b0;
  endtask

  initial begin
    a_if.if_req = 1'b0; a_if.if_addr = '0;
    a_if.dm_req = 1'b0; a_if.dm_we = 1'b0; a_if.dm_addr = '0; a_if.dm_wdata = '0;
    b_if.if_req = 1'b0; b_if.if_addr = '0;
    b_if.dm_req = 1'b0; b_if.dm_we = 1'b0; b_if.dm_addr = '0; b_if.dm_wdata = '0;
    test_reset();
    test_single_fetch();
    test_dm_write();
    test_collision();
    test_starvation();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end
endmodule
